md_unit: RTL
============

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL use parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 SHALL use parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  E-stage md instruction valid this cycle.
REQ-006 SHALL have port md_op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6–7 reserved.
REQ-007 SHALL have port rs_val  input  32  forwarded GRF[rs] operand from E stage.
REQ-008 SHALL have port rt_val  input  32  forwarded GRF[rt] operand from E stage.
REQ-009 SHALL have port hilo_sel  input  1  mfhi/mflo read select: 1 HI, 0 LO.
REQ-010 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-011 SHALL have port md_stall  output  1  combinational start|busy, to the hazard unit.
REQ-012 SHALL have port hi  output  32  architectural HI register.
REQ-013 SHALL have port lo  output  32  architectural LO register.
REQ-014 SHALL have port rd_val  output  32  hilo_sel ? hi : lo, combinational, for mf forwarding.

Function
REQ-015 SHALL latch rs_val, rt_val and md_op at the edge where start=1 and busy=0 (accept edge); the operands SHALL NOT be sampled again.
REQ-016 SHALL ignore start while busy=1: no state change.
REQ-017 SHALL ignore reserved md_op codes 6–7: no state change, busy stays 0.
REQ-018 SHALL implement mthi/mtlo with zero latency: hi (resp. lo) <= rs_val at the accept edge, with busy staying 0.
REQ-019 SHALL raise busy at the accept edge of mult/multu/div/divu and hold it for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES), using a down-counter loaded with N.
REQ-020 SHALL write hi/lo at the edge that ends the Nth busy cycle, and SHALL clear busy at that same edge.
REQ-021 SHALL keep hi/lo at their old values throughout the busy window.
REQ-022 SHALL compute mult as a signed 64-bit product {hi,lo} and multu as an unsigned product.
REQ-023 SHALL compute div/divu as: lo = quotient truncated toward zero, hi = remainder with the dividend's sign; divu is unsigned.
REQ-024 SHALL leave hi/lo unchanged when the divisor is 0; busy still runs the full DIV_CYCLES.
REQ-025 SHALL produce lo=0x80000000, hi=0 for signed 0x80000000 / 0xFFFFFFFF, with no trap.
REQ-026 SHALL accept a start asserted in the same cycle busy falls (counter reaches 0) only at the next edge, because busy is still 1 in that cycle.
REQ-027 SHALL drive rd_val from hi/lo registers only; it SHALL never expose in-flight results.
REQ-028 SHALL implement two states, IDLE and RUN: IDLE->RUN on an accepted mult/div start; RUN->IDLE when the counter is 1 at an edge.

Reset
REQ-029 SHALL force, on rst_n=0 and asynchronously: busy=0, counter=0, state IDLE, hi=0, lo=0.
REQ-030 SHALL discard any in-flight result when reset is asserted mid-operation; hi/lo remain 0 after release.
REQ-031 SHALL ignore start while rst_n=0; the first accept is possible at the first rising edge with rst_n=1.

Structure
REQ-032 SHALL place the md_op encodings, MULT_CYCLES/DIV_CYCLES defaults and IDLE/RUN state encoding in the shared pipeline definitions package, alongside the opcode/func constants.
REQ-033 SHALL use one sub-module, md_alu: a combinational 64-bit result from latched operands and op, instantiated once; the counter/FSM stays in md_unit.

Verification
REQ-034 SHALL cover mult: rs=0xFFFFFFFE, rt=3, start one cycle -> busy high 5 cycles, md_stall high 6 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-035 SHALL cover multu: same operands -> hi=0x00000002, lo=0xFFFFFFFA after 5 busy cycles.
REQ-036 SHALL cover div: rs=-7 (0xFFFFFFF9), rt=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; then div rt=0 -> hi/lo unchanged, busy still 10 cycles.
REQ-037 SHALL cover mthi during busy: mthi rs=0x1234 issued in busy cycle 3 of a mult -> ignored; the same mthi after busy falls -> hi=0x1234 next edge, busy stays 0.
REQ-038 SHALL cover reset mid-op: divu 100/7 started, rst_n low in busy cycle 4 -> busy=0, hi=lo=0 immediately; no late write after release.
REQ-039 SHALL cover back-to-back: start held high across the final busy cycle -> second op accepted exactly at the edge after busy falls, with its operands sampled at that edge.

Source files
------------

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared pipeline definitions for the multiply/divide unit.
package md_unit_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1a;
    localparam logic [5:0] FN_DIVU    = 6'h1b;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} md_state_e;

    // mult/multu/div/divu occupy codes 0-3 and are the only multi-cycle ops
    function automatic logic is_long(logic [2:0] op);
        return op <= 3'd3;
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: E-stage request and HI/LO result bundle of the md unit.
interface md_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hilo_sel;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_val;

    modport master (output start, md_op, rs_val, rt_val, hilo_sel,
                    input  busy, md_stall, hi, lo, rd_val);
    modport slave  (input  start, md_op, rs_val, rt_val, hilo_sel,
                    output busy, md_stall, hi, lo, rd_val);
endinterface

// File: rtl/md_alu.sv
// md_alu: combinational 64-bit {hi,lo} result for mult/multu/div/divu.
module md_alu
    import md_unit_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_res
);
    logic [63:0]        w_smul, w_umul;
    logic signed [31:0] w_sq, w_sr;
    logic [31:0]        w_uq, w_ur;
    logic               w_ovf;

    assign w_smul = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_umul = {32'b0, i_a} * {32'b0, i_b};
    assign w_sq   = $signed(i_a) / $signed(i_b);
    assign w_sr   = $signed(i_a) % $signed(i_b);
    assign w_uq   = i_a / i_b;
    assign w_ur   = i_a % i_b;
    // INT_MIN / -1 wraps to INT_MIN with zero remainder instead of trapping
    assign w_ovf  = i_a == 32'h8000_0000 && i_b == 32'hFFFF_FFFF;

    always_comb
        o_res = i_op == MD_MULT  ? w_smul :
                i_op == MD_MULTU ? w_umul :
                i_op == MD_DIV   ? (w_ovf ? {32'h0, 32'h8000_0000} : {w_sr, w_sq}) :
                                   {w_ur, w_uq};
endmodule

// File: rtl/md_unit.sv
// md_unit: MIPS HI/LO multiply/divide unit with fixed-latency busy window.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    md_unit_if.slave bus
);
    localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);

    md_state_e   r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b, r_hi, r_lo, w_hi_nxt, w_lo_nxt;
    logic [63:0] w_res;
    logic        w_busy, w_accept, w_long, w_done;

    assign w_busy   = r_state == RUN;
    assign w_accept = bus.start && !w_busy;
    assign w_long   = is_long(bus.md_op);
    assign w_done   = w_busy && r_cnt == CW'(1);

    md_alu u_alu (.i_op(r_op), .i_a(r_a), .i_b(r_b), .o_res(w_res));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        if (!w_busy) begin
            if (w_accept && w_long) begin
                w_state_nxt = RUN;
                w_cnt_nxt   = bus.md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end
            w_hi_nxt = w_accept && bus.md_op == MD_MTHI ? bus.rs_val : r_hi;
            w_lo_nxt = w_accept && bus.md_op == MD_MTLO ? bus.rs_val : r_lo;
        end else begin
            w_cnt_nxt = r_cnt - CW'(1);
            if (w_done) begin
                w_state_nxt = IDLE;
                // a zero divisor leaves HI/LO untouched
                if (!(r_op[1] && r_b == 32'h0))
                    {w_hi_nxt, w_lo_nxt} = w_res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && w_long) begin
            r_op <= bus.md_op;
            r_a  <= bus.rs_val;
            r_b  <= bus.rt_val;
        end
    end

    assign bus.busy     = w_busy;
    assign bus.md_stall = bus.start | w_busy;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.rd_val   = bus.hilo_sel ? r_hi : r_lo;
endmodule
